cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Sequences and shares the single block-wide main memory (10-bit byte address, 128-bit block) between two cache controllers (port 0, port 1), e.g. instruction and data cache.
- Serialises block reads (refills) and block writes (write-through/write-back) with round-robin fairness.
- Models memory access time with a fixed latency counter.
- Drives the asynchronous memory's read_write/address/writeData pins.

Parameters:
- ADDR_W, 10, byte address width
- BLOCK_W, 128, block width (4 x 32-bit words)
- MEM_LAT, 4, memory access cycles per transaction (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request; held with operands until done0
- we0  in  1  port 0: 1 = block write, 0 = block read
- addr0  in  ADDR_W  port 0 block address (bits [3:0] ignored)
- wdata0  in  BLOCK_W  port 0 write block
- done0  out  1  one-cycle completion pulse to port 0
- req1, we1, addr1, wdata1, done1  same as port 0, for port 1
- rdata  out  BLOCK_W  registered read block; valid while done0/done1 is high
- busy  out  1  high when state != IDLE
- owner  out  1  port currently served; meaningful while busy
- mem_read_write  out  1  to memory: 1 = write
- mem_address  out  ADDR_W  to memory
- mem_write_data  out  BLOCK_W  to memory
- mem_read_data  in  BLOCK_W  from memory, combinational

Behaviour:
- Reset values (asynchronous):
  - state = IDLE.
  - All outputs 0, including done0/1, busy, owner, rdata, mem_read_write, mem_address and mem_write_data.
  - last_grant = 1, so port 0 wins the first tie.
  - Latency counter cnt = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - At a rising edge with any req high: latch winner's we/addr (low 4 bits forced 0)/wdata into we_q/addr_q/wdata_q.
  - Set owner = winner and last_grant = winner, cnt = MEM_LAT-1, then go to BUSY.
  - Arbitration: single requester wins. If both request, the port != last_grant wins.
- BUSY:
  - mem_address = addr_q and mem_write_data = wdata_q, held stable for the whole state.
  - Each edge: if cnt != 0, cnt decrements. If cnt == 0, go to DONE; if !we_q, rdata <= mem_read_data.
  - mem_read_write = we_q && cnt == 0, combinational from registered state. The write strobe is exactly one cycle, the last BUSY cycle. mem_read_write = 0 at all other times.
- DONE:
  - Exactly one cycle. done[owner] = 1, the other done = 0. Next edge returns to IDLE.
  - rdata holds its value until the next completed read; it is unchanged by writes.
- Latency: request accepted at edge k. done is high between edges k+MEM_LAT and k+MEM_LAT+1. Throughput is one transaction per MEM_LAT+2 cycles.
- Requester rules:
  - Deassert req (or present a new request) in the cycle after done.
  - A req still high at the first IDLE edge is a new transaction.
- Request changes while not owner: ignored until sampled in IDLE. The operands of the owning port are ignored after latching.
- Simultaneous req0/req1 every opportunity: grants strictly alternate.
- Reset mid-transaction: transaction abandoned, no done pulse, mem_read_write drops immediately. A write is not committed unless its strobe cycle has already completed.
- MEM_LAT = 1: BUSY lasts one cycle, and that cycle carries the write strobe.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W, BLOCK_W, WORD_W = 32
  - Address field slices: TAG [9:6], INDEX [5:4], WORD [3:2], BYTE [1:0]
  - State enum {IDLE, BUSY, DONE}
  - Memory opcode constants MEM_READ = 0, MEM_WRITE = 1
- One sub-module: rr_arbiter2 (req[1:0], last_grant -> grant, valid), purely combinational.
- FSM, counter and operand latch stay in cache_mem_arbiter.

Test Plan:
- Single read, MEM_LAT = 4: memory holds 0x1111...@addr 0x040; req0 = 1, we0 = 0, addr0 = 0x04C.
  - mem_address = 0x040.
  - done0 pulses exactly 4 cycles after acceptance, with rdata = 0x1111...
  - done1 stays 0 and mem_read_write stays 0 throughout.
- Single write, port 1, addr1 = 0x3F0, wdata1 = 0xDEADBEEF_...:
  - mem_read_write is high for exactly the one cycle before done1.
  - A later read of 0x3F0 returns the written block.
- Tie after reset: req0 and req1 asserted in the same cycle.
  - Port 0 served first (owner = 0), then port 1.
  - Third round with both requesting grants 0 again (strict alternation).
- Back-to-back port 0 with port 1 idle: req0 reasserted the cycle after done0.
  - Second transaction starts immediately. Transaction start spacing = MEM_LAT+2 = 6 cycles.
- Reset mid-write: assert reset on cnt = 2 of a write.
  - All outputs 0 immediately, no done, mem_read_write never pulses.
  - After release, a pending req1 is served normally.
- Operand stability: change addr1 while port 0 is owner, and change addr0 during port 0's BUSY.
  - mem_address stays addr_q for the whole BUSY.
  - The port-1 change takes effect only when port 1 is next accepted.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache/main-memory path: widths, address fields,
// arbiter FSM states and memory opcodes.
package cache_pkg;

   localparam int ADDR_W      = 10;
   localparam int BLOCK_W     = 128;
   localparam int WORD_W      = 32;
   localparam int BLOCK_OFS_W = 4;

   // Byte address fields: tag | index | word | byte
   localparam int TAG_HI   = 9;
   localparam int TAG_LO   = 6;
   localparam int INDEX_HI = 5;
   localparam int INDEX_LO = 4;
   localparam int WORD_HI  = 3;
   localparam int WORD_LO  = 2;
   localparam int BYTE_HI  = 1;
   localparam int BYTE_LO  = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins; on a tie the port that
// was not granted last wins.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       valid
);

   always_comb begin
      valid = |req;
      grant = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one block-wide asynchronous main memory between two cache ports,
// one transaction at a time, with a fixed access latency per transaction.
module cache_mem_arbiter #(
   parameter int ADDR_W  = cache_pkg::ADDR_W,
   parameter int BLOCK_W = cache_pkg::BLOCK_W,
   parameter int MEM_LAT = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic               we0,
   input  logic [ADDR_W-1:0]  addr0,
   input  logic [BLOCK_W-1:0] wdata0,
   output logic               done0,
   input  logic               req1,
   input  logic               we1,
   input  logic [ADDR_W-1:0]  addr1,
   input  logic [BLOCK_W-1:0] wdata1,
   output logic               done1,
   output logic [BLOCK_W-1:0] rdata,
   output logic               busy,
   output logic               owner,
   output logic               mem_read_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_write_data,
   input  logic [BLOCK_W-1:0] mem_read_data
);

   import cache_pkg::*;

   state_t             state;
   state_t             state_next;
   logic               last_grant;
   logic               grant;
   logic               arb_valid;
   logic               we_q;
   logic               owner_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [BLOCK_W-1:0] wdata_q;
   logic [BLOCK_W-1:0] rdata_q;
   logic [3:0]         cnt;

   rr_arbiter2 u_arb (
      .req        ({req1, req0}),
      .last_grant (last_grant),
      .grant      (grant),
      .valid      (arb_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (arb_valid) state_next = BUSY;
         BUSY:    if (cnt == 4'd0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand latch, latency counter and read capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b1;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         cnt        <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  owner_q    <= grant;
                  last_grant <= grant;
                  we_q       <= grant ? we1 : we0;
                  addr_q     <= grant ? {addr1[ADDR_W-1:BLOCK_OFS_W], {BLOCK_OFS_W{1'b0}}}
                                      : {addr0[ADDR_W-1:BLOCK_OFS_W], {BLOCK_OFS_W{1'b0}}};
                  wdata_q    <= grant ? wdata1 : wdata0;
                  cnt        <= 4'(MEM_LAT - 1);
               end
            end
            BUSY: begin
               if (cnt != 4'd0)  cnt <= cnt - 4'd1;
               else if (!we_q)   rdata_q <= mem_read_data;
            end
            default: ;
         endcase
      end
   end

   // Memory pins are only driven while a transaction is in flight, so a
   // reset drops them in the same instant the state register clears.
   always_comb begin
      busy           = (state != IDLE);
      owner          = owner_q;
      rdata          = rdata_q;
      done0          = (state == DONE) && !owner_q;
      done1          = (state == DONE) &&  owner_q;
      mem_read_write = MEM_READ;
      mem_address    = '0;
      mem_write_data = '0;
      if (state == BUSY) begin
         mem_read_write = (we_q && cnt == 4'd0) ? MEM_WRITE : MEM_READ;
         mem_address    = addr_q;
         mem_write_data = wdata_q;
      end
   end

endmodule
